systolic_skew_feeder: RTL and testbench
=======================================

Name: systolic_skew_feeder

Overview:
Upstream edge feeder for the num_of_PE x num_of_PE systolic multiply array. Each handshake beat accepts one column of A and one row of B for one k index. It drives them skewed onto the array's left edge (A) and top edge (B), so that PE(i,j) receives a[i][k] and b[k][j] in the same cycle. A control FSM sequences accumulator clear, streaming of k_len beats, and pipeline flush, then pulses done when every PE result is final.

Parameters:
data_width, 8, bits per matrix element.
num_of_PE, 4, array dimension N; number of lanes per edge.
k_width, 8, width of the inner-dimension length k_len.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset; asynchronous, active-high.
start  input  1  request a new multiply; sampled only in IDLE.
k_len  input  k_width  inner dimension K; latched on an accepted start.
in_valid  input  1  a_col/b_row beat valid.
in_ready  output  1  feeder accepts a beat this cycle.
a_col  input  data_width*num_of_PE  lane i (bits [i*dw +: dw]) = a[i][k].
b_row  input  data_width*num_of_PE  lane j = b[k][j].
left_out  output  data_width*num_of_PE  lane i drives the in_left of row i, column 0.
up_out  output  data_width*num_of_PE  lane j drives the in_up of row 0, column j.
acc_clr  output  1  one-cycle clear request to the array accumulators.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse; all PE results valid this cycle.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; all skew registers, left_out and up_out = 0.
  - in_ready=0, acc_clr=0, busy=0, done=0; beat counter=0.
  - Takes effect immediately, including mid-stream or mid-flush. The partial job is abandoned and no done is issued.
- FSM states: IDLE -> CLEAR -> STREAM -> FLUSH -> DONE -> IDLE.
  - IDLE: start=1 and k_len!=0 -> latch k_len, go to CLEAR. start with k_len=0 is ignored (stay IDLE, no done).
  - CLEAR: exactly 1 cycle; acc_clr=1; edge outputs 0; go to STREAM.
  - STREAM: in_ready=1.
    - Beat accepted when in_valid & in_ready; count increments.
    - On the beat that makes count==k_len, go to FLUSH.
    - Cycles with in_valid=0 inject zeros on all lanes (a bubble). This keeps wavefronts aligned and contributes a 0 product.
  - FLUSH: in_ready=0; zeros pushed for exactly 2*num_of_PE-1 cycles; then go to DONE.
  - DONE: 1 cycle; done=1; busy=1; go to IDLE.
- start while busy is ignored. in_valid while in_ready=0 is ignored (no acceptance).
- Skew timing: the beat accepted in cycle c appears on lane i of left_out/up_out in cycle c+1+i. Lane 0 has one register stage; lane i has i+1 stages.
  - Data is pushed unmodified; no arithmetic and no width change.
  - Lanes shift every cycle in all states; the register input is 0 when no beat is accepted.
- Result timing: with the last beat accepted in cycle c0, PE(N-1,N-1) accumulates at the end of cycle c0+2N-1. done is asserted in cycle c0+2N.
- Outputs are zero in IDLE once the flush has drained. A new job's CLEAR cycle drives zeros to the edges.

Test Plan:
- Reset: rst=1 mid-idle with random inputs -> all outputs 0 immediately. After release: busy=0, in_ready=0.
- Single beat, N=4, dw=8: start with k_len=1, accept a_col lanes {1,2,3,4}, b_row lanes {2,2,2,2} in cycle c0.
  - left_out lane0=1 in c0+1, lane1=2 in c0+2, lane2=3 in c0+3, lane3=4 in c0+4, each for one cycle, else 0.
  - acc_clr=1 only in c0-1.
  - done=1 exactly in c0+8.
- Bubble: k_len=3, in_valid low for one cycle between beats 1 and 2.
  - Lanes show a zero gap shifted by i on each lane; 3 beats accepted; done 8 cycles after the 3rd acceptance.
  - With the array attached, results equal the reference 4x4x3 matrix product.
- Ignored requests:
  - start with k_len=0 -> stays IDLE, no acc_clr.
  - start during STREAM -> no effect.
  - in_valid during FLUSH -> in_ready=0, no lane change.
- Mid-operation reset: assert rst in the 2nd FLUSH cycle.
  - Outputs go to 0 asynchronously; no done is produced.
  - After release, a new k_len=2 job completes normally with done 8 cycles after its last beat.
- Back-to-back: assert start in the cycle after done (IDLE).
  - CLEAR follows; left_out of the new job is not corrupted by residual data from the old job.

Source files
------------

// File: rtl/systolic_skew_feeder_if.sv
// Handshake and edge bus between the job source, the skew feeder and the systolic array edges.
interface systolic_skew_feeder_if #(
  parameter int data_width = 8,
  parameter int num_of_PE  = 4,
  parameter int k_width    = 8
);
  logic                            start;
  logic [k_width-1:0]              k_len;
  logic                            in_valid;
  logic                            in_ready;
  logic [data_width*num_of_PE-1:0] a_col;
  logic [data_width*num_of_PE-1:0] b_row;
  logic [data_width*num_of_PE-1:0] left_out;
  logic [data_width*num_of_PE-1:0] up_out;
  logic                            acc_clr;
  logic                            busy;
  logic                            done;

  modport master (
    output start, k_len, in_valid, a_col, b_row,
    input  in_ready, left_out, up_out, acc_clr, busy, done
  );

  modport slave (
    input  start, k_len, in_valid, a_col, b_row,
    output in_ready, left_out, up_out, acc_clr, busy, done
  );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Skewed edge feeder for an N x N systolic multiply array: lane i is delayed i+1 cycles,
// with a clear / stream / flush / done sequencer around it.
module skew_lane #(
  parameter int DW    = 8,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  logic [DEPTH-1:0][DW-1:0] sr_q, sr_d;

  always_comb begin
    sr_d[0] = d;
    for (int s = 1; s < DEPTH; s++) sr_d[s] = sr_q[s-1];
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;

  assign q = sr_q[DEPTH-1];
endmodule

module systolic_skew_feeder #(
  parameter int data_width = 8,
  parameter int num_of_PE  = 4,
  parameter int k_width    = 8
) (
  input logic                  clk,
  input logic                  rst,
  systolic_skew_feeder_if.slave bus
);
  localparam int FLUSH_LEN = 2*num_of_PE - 1;
  localparam int FW        = $clog2(2*num_of_PE);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_FLUSH, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [k_width-1:0] k_q, k_d;
  logic [k_width-1:0] cnt_q, cnt_d;
  logic [FW-1:0]      flush_q, flush_d;
  logic               in_ready, acc_clr, busy, done, accept;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    flush_d  = flush_q;
    in_ready = 1'b0;
    acc_clr  = 1'b0;
    done     = 1'b0;
    busy     = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:
        if (bus.start && (bus.k_len != '0)) begin
          k_d     = bus.k_len;
          cnt_d   = '0;
          state_d = S_CLEAR;
        end
      S_CLEAR: begin
        acc_clr = 1'b1;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == k_q - 1'b1) begin
            flush_d = '0;
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH:
        // Long enough for the last beat to cross the far corner PE.
        if (flush_q == FW'(FLUSH_LEN - 1)) state_d = S_DONE;
        else                               flush_d = flush_q + 1'b1;
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept = bus.in_valid & in_ready;

  logic [num_of_PE-1:0][data_width-1:0] left_lanes, up_lanes;

  // Non-accepted cycles inject zeros so wavefronts stay aligned.
  for (genvar i = 0; i < num_of_PE; i++) begin : g_lane
    skew_lane #(.DW(data_width), .DEPTH(i+1)) u_a (
      .clk (clk), .rst (rst),
      .d   (accept ? bus.a_col[i*data_width +: data_width] : '0),
      .q   (left_lanes[i])
    );
    skew_lane #(.DW(data_width), .DEPTH(i+1)) u_b (
      .clk (clk), .rst (rst),
      .d   (accept ? bus.b_row[i*data_width +: data_width] : '0),
      .q   (up_lanes[i])
    );
  end

  assign bus.left_out = left_lanes;
  assign bus.up_out   = up_lanes;
  assign bus.in_ready = in_ready;
  assign bus.acc_clr  = acc_clr;
  assign bus.busy     = busy;
  assign bus.done     = done;
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder with a reference 4x4 PE array hung on its edges.
module tb_systolic_skew_feeder;
  localparam int DW = 8, N = 4, KW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_skew_feeder_if #(.data_width(DW), .num_of_PE(N), .k_width(KW)) bus ();
  systolic_skew_feeder #(.data_width(DW), .num_of_PE(N), .k_width(KW)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );

  int n_tests = 0, n_fail = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference sequencer and scoreboard producer
  typedef struct { int due; logic [DW-1:0] a; logic [DW-1:0] b; } exp_t;
  exp_t lq [N][$];
  int   done_q [$];
  int   m_st = 0, m_k = 0, m_cnt = 0, m_f = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st <= 0; m_k <= 0; m_cnt <= 0; m_f <= 0;
      for (int i = 0; i < N; i++) lq[i].delete();
      done_q.delete();
    end else begin
      case (m_st)
        0: if (bus.start && bus.k_len != 0) begin m_k <= int'(bus.k_len); m_st <= 1; end
        1: begin m_st <= 2; m_cnt <= 0; end
        2: if (bus.in_valid) begin
             for (int i = 0; i < N; i++)
               lq[i].push_back('{cyc + 1 + i, bus.a_col[i*DW +: DW], bus.b_row[i*DW +: DW]});
             m_cnt <= m_cnt + 1;
             if (m_cnt + 1 == m_k) begin
               m_st <= 3; m_f <= 0;
               done_q.push_back(cyc + 2*N);
             end
           end
        3: if (m_f == 2*N - 2) m_st <= 4; else m_f <= m_f + 1;
        default: m_st <= 0;
      endcase
    end
  end

  // Reference PE array driven from the DUT edges
  int pa [N][N], pb [N][N], acc [N][N];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
        pa[i][j] <= 0; pb[i][j] <= 0; acc[i][j] <= 0;
      end
    end else begin
      for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
        int ai, bi;
        if (j == 0) ai = int'(bus.left_out[i*DW +: DW]); else ai = pa[i][j-1];
        if (i == 0) bi = int'(bus.up_out[j*DW +: DW]);   else bi = pb[i-1][j];
        pa[i][j]  <= ai;
        pb[i][j]  <= bi;
        acc[i][j] <= bus.acc_clr ? 0 : acc[i][j] + ai*bi;
      end
    end
  end

  // Monitor / scoreboard consumer
  int clr_cyc = -1, done_cyc = -1, n_done = 0, n_acc = 0;
  always @(negedge clk) begin
    if (!rst) begin
      logic [DW-1:0] ea, eb;
      logic          ed;
      for (int i = 0; i < N; i++) begin
        ea = '0; eb = '0;
        if (lq[i].size() != 0 && lq[i][0].due == cyc) begin
          ea = lq[i][0].a; eb = lq[i][0].b;
          void'(lq[i].pop_front());
        end
        chk($sformatf("left%0d@%0d", i, cyc), 64'(bus.left_out[i*DW +: DW]), 64'(ea));
        chk($sformatf("up%0d@%0d", i, cyc),   64'(bus.up_out[i*DW +: DW]),   64'(eb));
      end
      ed = 1'b0;
      if (done_q.size() != 0 && done_q[0] == cyc) begin ed = 1'b1; void'(done_q.pop_front()); end
      chk($sformatf("done@%0d", cyc),     64'(bus.done),     64'(ed));
      chk($sformatf("in_ready@%0d", cyc), 64'(bus.in_ready), 64'(m_st == 2));
      chk($sformatf("acc_clr@%0d", cyc),  64'(bus.acc_clr),  64'(m_st == 1));
      chk($sformatf("busy@%0d", cyc),     64'(bus.busy),     64'(m_st != 0));
      if (bus.acc_clr) clr_cyc = cyc;
      if (bus.done) begin done_cyc = cyc; n_done++; end
      if (bus.in_valid && bus.in_ready) n_acc++;
    end
  end

  int a_stim [8][N], b_stim [8][N];

  task automatic drive_beat(input int b);
    for (int i = 0; i < N; i++) begin
      bus.a_col[i*DW +: DW] = DW'(a_stim[b][i]);
      bus.b_row[i*DW +: DW] = DW'(b_stim[b][i]);
    end
  endtask

  task automatic run_job(input int k, input int bubble_at, input logic strm_start, output int last_c);
    int b;
    bit bub;
    b = 0; bub = 0; last_c = -1;
    bus.start = 1'b1; bus.k_len = KW'(k); tick();
    bus.start = 1'b0; bus.in_valid = 1'b1; drive_beat(0); tick();
    while (b < k) begin
      if (b == bubble_at && !bub) begin
        bub = 1; bus.in_valid = 1'b0; bus.start = strm_start; bus.k_len = KW'(5);
      end else begin
        bus.in_valid = 1'b1; drive_beat(b); last_c = cyc; b++;
      end
      tick();
      bus.start = 1'b0;
    end
    // Traffic during the first flush cycle must be refused.
    bus.in_valid = 1'b1; bus.a_col = $urandom; bus.b_row = $urandom; tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic check_products(input string tag, input int k);
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
      int r = 0;
      for (int kk = 0; kk < k; kk++) r += a_stim[kk][i] * b_stim[kk][j];
      chk($sformatf("%s_c%0d%0d", tag, i, j), 64'(acc[i][j]), 64'(r));
    end
  endtask

  task automatic rand_stim(input int k);
    for (int kk = 0; kk < k; kk++) for (int i = 0; i < N; i++) begin
      a_stim[kk][i] = int'($urandom_range(0, 255));
      b_stim[kk][i] = int'($urandom_range(0, 255));
    end
  endtask

  initial begin
    int lc;
    bus.start = 1'b0; bus.k_len = '0; bus.in_valid = 1'b0;
    bus.a_col = $urandom; bus.b_row = $urandom;
    #2;
    chk("rst_left", 64'(bus.left_out), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    tick(); tick(); rst = 1'b0; tick(); tick();

    // Reset in idle with junk on the inputs
    bus.a_col = $urandom; bus.b_row = $urandom; bus.in_valid = 1'b1; bus.k_len = KW'($urandom);
    rst = 1'b1; #1;
    chk("rst2_left", 64'(bus.left_out), 64'd0);
    chk("rst2_up",   64'(bus.up_out),   64'd0);
    chk("rst2_done", 64'(bus.done),     64'd0);
    tick(); rst = 1'b0; bus.in_valid = 1'b0; tick();
    chk("post_rst_busy",  64'(bus.busy),     64'd0);
    chk("post_rst_ready", 64'(bus.in_ready), 64'd0);

    // start with k_len == 0 is dropped
    bus.start = 1'b1; bus.k_len = '0; tick(); bus.start = 1'b0; tick();
    chk("k0_busy", 64'(bus.busy), 64'd0);
    tick();

    // Single beat with fixed data
    for (int i = 0; i < N; i++) begin a_stim[0][i] = i + 1; b_stim[0][i] = 2; end
    run_job(1, -1, 1'b0, lc);
    repeat (lc + 9 - cyc) tick();
    chk("single_clr_cyc",  64'(clr_cyc),  64'(lc - 1));
    chk("single_done_cyc", 64'(done_cyc), 64'(lc + 8));
    check_products("single", 1);
    tick();

    // Bubble between beats 1 and 2, plus a start while streaming
    rand_stim(3);
    n_acc = 0;
    run_job(3, 1, 1'b1, lc);
    repeat (lc + 9 - cyc) tick();
    chk("bubble_beats",    64'(n_acc),    64'd3);
    chk("bubble_done_cyc", 64'(done_cyc), 64'(lc + 8));
    check_products("bubble", 3);

    // Back-to-back: start in the cycle right after done
    rand_stim(2);
    run_job(2, -1, 1'b0, lc);
    repeat (lc + 9 - cyc) tick();
    chk("b2b_done_cyc", 64'(done_cyc), 64'(lc + 8));
    check_products("b2b", 2);
    tick();

    // Reset in the second flush cycle abandons the job
    rand_stim(1);
    run_job(1, -1, 1'b0, lc);
    begin
      int nd0;
      nd0 = n_done;
      rst = 1'b1; #1;
      chk("midrst_left", 64'(bus.left_out), 64'd0);
      chk("midrst_up",   64'(bus.up_out),   64'd0);
      chk("midrst_busy", 64'(bus.busy),     64'd0);
      tick(); tick(); rst = 1'b0;
      repeat (12) tick();
      chk("midrst_no_done", 64'(n_done), 64'(nd0));
    end

    rand_stim(2);
    run_job(2, -1, 1'b0, lc);
    repeat (lc + 9 - cyc) tick();
    chk("after_rst_done_cyc", 64'(done_cyc), 64'(lc + 8));
    check_products("after_rst", 2);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
